// File: rtl/riscv_dispatch_pkg.sv
// riscv_dispatch_pkg: opcodes, queue targets and buffered packet layout for the dispatch stage
package riscv_dispatch_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam logic [6:0] R_TYPE = 7'h33;
  localparam logic [6:0] I_TYPE = 7'h13;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] LW     = 7'h03;
  localparam logic [6:0] S_TYPE = 7'h23;
  localparam logic [6:0] J_TYPE = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] B_TYPE = 7'h63;
  localparam logic [6:0] U_TYPE = 7'h17;
  typedef enum logic [2:0] {Q_INT, Q_LDST, Q_MULT, Q_DIV, Q_NONE} disp_target_e;
  typedef struct packed {
    logic [XLEN-1:0]  rs1_data;
    logic             rs1_valid;
    logic [TAG_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs2_data;
    logic             rs2_valid;
    logic [TAG_W-1:0] rs2_tag;
    logic [TAG_W-1:0] rd_tag;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [XLEN-1:0]  imm;
    logic             is_store;
  } disp_pkt_t;
  function automatic logic [3:0] target_onehot(disp_target_e t);
    return (t == Q_NONE) ? 4'b0000 : 4'b0001 << t;
  endfunction
endpackage

// File: rtl/dispatch_classify.sv
// dispatch_classify: opcode/func decode into issue-queue target and operand overrides
module dispatch_classify
  import riscv_dispatch_pkg::*;
#(
  parameter bit MDIV_FULL = 1'b1
) (
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   func3_i,
  input  logic [6:0]   func7_i,
  output disp_target_e target_o,
  output logic         rs2_imm_o,
  output logic         rs2_ok_o,
  output logic         is_store_o
);
  logic is_mul, is_div;
  assign is_mul = (func7_i == 7'd1) & (MDIV_FULL ? !func3_i[2] : (func3_i == 3'd0));
  assign is_div = (func7_i == 7'd1) & (MDIV_FULL ? func3_i[2] : (func3_i == 3'd4));
  // Steer by opcode; immediates replace rs2, loads have no rs2 dependency
  always_comb begin
    target_o   = Q_NONE;
    rs2_imm_o  = 1'b0;
    rs2_ok_o   = 1'b0;
    is_store_o = 1'b0;
    case (opcode_i)
      R_TYPE:              target_o = is_mul ? Q_MULT : is_div ? Q_DIV : Q_INT;
      I_TYPE, LUI: begin
        target_o  = Q_INT;
        rs2_imm_o = 1'b1;
        rs2_ok_o  = 1'b1;
      end
      LW: begin
        target_o = Q_LDST;
        rs2_ok_o = 1'b1;
      end
      S_TYPE: begin
        target_o   = Q_LDST;
        is_store_o = 1'b1;
      end
      JALR, B_TYPE, U_TYPE: target_o = Q_INT;
      default:             target_o = Q_NONE;
    endcase
  end
endmodule

// File: rtl/dispatch_stage_buf.sv
// dispatch_stage_buf: one-entry registered dispatch buffer with per-queue handshake and CDB snooping
module dispatch_stage_buf
  import riscv_dispatch_pkg::*;
#(
  parameter bit MDIV_FULL = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs1_decoded,
  input  logic [4:0]       rs2_decoded,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             rs1_sel_cdb_or_regfile,
  input  logic             rs2_sel_cdb_or_regfile,
  input  logic [TAG_W:0]   rs1_valid_plus_tag,
  input  logic [TAG_W:0]   rs2_valid_plus_tag,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [XLEN-1:0]  imm,
  input  logic             flush,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output disp_pkt_t        out_pkt,
  output logic [3:0]       out_valid,
  input  logic [3:0]       q_ready,
  output logic [CNT_W-1:0] stall_cnt
);
  disp_target_e     tgt_c, tgt_q, tgt_d;
  logic             rs2_imm_c, rs2_ok_c, is_store_c;
  logic             held_q, held_d, fire, accept;
  logic             v1, v2, byp1, byp2;
  disp_pkt_t        pkt_q, pkt_d;
  logic [CNT_W-1:0] stall_q;

  dispatch_classify #(.MDIV_FULL(MDIV_FULL)) u_classify (
    .opcode_i   (opcode),
    .func3_i    (func3),
    .func7_i    (func7),
    .target_o   (tgt_c),
    .rs2_imm_o  (rs2_imm_c),
    .rs2_ok_o   (rs2_ok_c),
    .is_store_o (is_store_c)
  );

  assign out_valid = held_q ? target_onehot(tgt_q) : 4'b0000;
  assign fire      = |(out_valid & q_ready);
  assign in_ready  = (!held_q | fire) & !flush;
  assign accept    = in_valid & in_ready;
  assign out_pkt   = pkt_q;
  assign stall_cnt = stall_q;

  assign v1   = (rs1_decoded == 5'd0) | rs1_sel_cdb_or_regfile | !rs1_valid_plus_tag[TAG_W];
  assign v2   = rs2_ok_c | (rs2_decoded == 5'd0) | rs2_sel_cdb_or_regfile | !rs2_valid_plus_tag[TAG_W];
  assign byp1 = !v1 & cdb_valid & (cdb_tag == rs1_valid_plus_tag[TAG_W-1:0]);
  assign byp2 = !v2 & cdb_valid & (cdb_tag == rs2_valid_plus_tag[TAG_W-1:0]);

  assign held_d = flush ? 1'b0 : accept ? (tgt_c != Q_NONE) : fire ? 1'b0 : held_q;
  assign tgt_d  = accept ? tgt_c : tgt_q;

  // Next packet: snoop the CDB into pending operands, or load a freshly accepted instruction
  always_comb begin
    pkt_d = pkt_q;
    if (cdb_valid & !pkt_q.rs1_valid & (cdb_tag == pkt_q.rs1_tag)) begin
      pkt_d.rs1_data  = cdb_data;
      pkt_d.rs1_valid = 1'b1;
    end
    if (cdb_valid & !pkt_q.rs2_valid & (cdb_tag == pkt_q.rs2_tag)) begin
      pkt_d.rs2_data  = cdb_data;
      pkt_d.rs2_valid = 1'b1;
    end
    if (accept) begin
      pkt_d.rs1_data  = byp1 ? cdb_data : rs1_data;
      pkt_d.rs1_valid = v1 | byp1;
      pkt_d.rs1_tag   = rs1_valid_plus_tag[TAG_W-1:0];
      pkt_d.rs2_data  = rs2_imm_c ? imm : byp2 ? cdb_data : rs2_data;
      pkt_d.rs2_valid = v2 | byp2;
      pkt_d.rs2_tag   = rs2_valid_plus_tag[TAG_W-1:0];
      pkt_d.rd_tag    = rd_tag;
      pkt_d.opcode    = opcode;
      pkt_d.func3     = func3;
      pkt_d.func7     = func7;
      pkt_d.imm       = imm;
      pkt_d.is_store  = is_store_c;
    end
  end

  // Holding register and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= 1'b0;
      tgt_q   <= Q_INT;
      pkt_q   <= '0;
      stall_q <= '0;
    end else begin
      held_q  <= held_d;
      tgt_q   <= tgt_d;
      pkt_q   <= pkt_d;
      stall_q <= (held_q & !fire & !flush & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    end
  end
endmodule

// File: tb/tb_dispatch_stage_buf.sv
// tb_dispatch_stage_buf: directed checks of dispatch_stage_buf in both MDIV_FULL modes
module tb_dispatch_stage_buf;
  import riscv_dispatch_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, flush, cdb_valid, rs1_sel, rs2_sel;
  logic [4:0] rs1_dec, rs2_dec;
  logic [XLEN-1:0] rs1_d, rs2_d, imm, cdb_data;
  logic [TAG_W:0] rs1_vt, rs2_vt;
  logic [TAG_W-1:0] rd_tag, cdb_tag;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic [3:0] q_ready;
  logic ir1, ir0;
  logic [3:0] ov1, ov0;
  disp_pkt_t pk1, pk0;
  logic [15:0] sc1;
  logic [2:0] sc0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  dispatch_stage_buf #(.MDIV_FULL(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .rs1_decoded(rs1_dec), .rs2_decoded(rs2_dec), .rs1_data(rs1_d), .rs2_data(rs2_d),
    .rs1_sel_cdb_or_regfile(rs1_sel), .rs2_sel_cdb_or_regfile(rs2_sel),
    .rs1_valid_plus_tag(rs1_vt), .rs2_valid_plus_tag(rs2_vt), .rd_tag(rd_tag),
    .opcode(opcode), .func3(func3), .func7(func7), .imm(imm), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_pkt(pk1), .out_valid(ov1), .q_ready(q_ready), .stall_cnt(sc1));

  dispatch_stage_buf #(.MDIV_FULL(1'b0), .CNT_W(3)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .rs1_decoded(rs1_dec), .rs2_decoded(rs2_dec), .rs1_data(rs1_d), .rs2_data(rs2_d),
    .rs1_sel_cdb_or_regfile(rs1_sel), .rs2_sel_cdb_or_regfile(rs2_sel),
    .rs1_valid_plus_tag(rs1_vt), .rs2_valid_plus_tag(rs2_vt), .rd_tag(rd_tag),
    .opcode(opcode), .func3(func3), .func7(func7), .imm(imm), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_pkt(pk0), .out_valid(ov0), .q_ready(q_ready), .stall_cnt(sc0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 0; flush = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    rs1_sel = 0; rs2_sel = 0; rs1_dec = 5'd1; rs2_dec = 5'd2;
    rs1_d = 32'h1111; rs2_d = 32'h2222; imm = 0; rs1_vt = 0; rs2_vt = 0;
    rd_tag = 6'd3; opcode = 0; func3 = 0; func7 = 0; q_ready = 4'hF;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    in_valid = 1; opcode = op; func3 = f3; func7 = f7;
  endtask

  initial begin
    clr();
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_ov", ov1, 4'b0000);
    chk("rst_stall", sc1, 16'd0);
    chk("rst_pkt_zero", pk1 == '0, 1'b1);
    tick();
    chk("rst_in_ready", ir1, 1'b1);
    // ADD to INT, one cycle only
    instr(R_TYPE, 3'd0, 7'd0);
    tick(); clr(); #1;
    chk("add_ov", ov1, 4'b0001);
    chk("add_in_ready", ir1, 1'b1);
    tick();
    chk("add_ov_clear", ov1, 4'b0000);
    // MUL, DIV, f3=1 back-to-back in both modes
    instr(R_TYPE, 3'd0, 7'd1);
    tick(); instr(R_TYPE, 3'd4, 7'd1); #1;
    chk("mul_ov_full", ov1, 4'b0100);
    chk("mul_ov_lite", ov0, 4'b0100);
    chk("mul_in_ready", ir1, 1'b1);
    tick(); instr(R_TYPE, 3'd1, 7'd1); #1;
    chk("div_ov_full", ov1, 4'b1000);
    chk("div_ov_lite", ov0, 4'b1000);
    tick(); clr(); #1;
    chk("f3_1_ov_full", ov1, 4'b0100);
    chk("f3_1_ov_lite", ov0, 4'b0001);
    tick();
    chk("mdiv_drain", ov1, 4'b0000);
    // ADDI: rs2 replaced by immediate regardless of pending bit
    instr(I_TYPE, 3'd0, 7'd0); imm = 32'h10; rs2_vt = 7'h45; rs2_d = 32'h99;
    tick(); clr(); #1;
    chk("addi_ov", ov1, 4'b0001);
    chk("addi_rs2_data", pk1.rs2_data, 32'h10);
    chk("addi_rs2_valid", pk1.rs2_valid, 1'b1);
    tick();
    // LW with pending rs1, LDST blocked for 3 cycles, CDB wakes rs1 in cycle 2
    instr(LW, 3'd2, 7'd0); rs1_vt = 7'h45; rs2_vt = 7'h46; q_ready = 4'b1101;
    tick(); in_valid = 0; #1;
    chk("lw_ov", ov1, 4'b0010);
    chk("lw_in_ready_c1", ir1, 1'b0);
    chk("lw_rs1_pending", pk1.rs1_valid, 1'b0);
    chk("lw_rs2_valid", pk1.rs2_valid, 1'b1);
    chk("lw_not_store", pk1.is_store, 1'b0);
    tick();
    cdb_valid = 1; cdb_tag = 6'd5; cdb_data = 32'hABCD; #1;
    chk("lw_in_ready_c2", ir1, 1'b0);
    tick();
    cdb_valid = 0; #1;
    chk("lw_rs1_data", pk1.rs1_data, 32'hABCD);
    chk("lw_rs1_valid", pk1.rs1_valid, 1'b1);
    chk("lw_in_ready_c3", ir1, 1'b0);
    tick();
    q_ready = 4'hF; #1;
    chk("lw_stall", sc1, 16'd3);
    chk("lw_stall_lite", sc0, 3'd3);
    chk("lw_fire_ready", ir1, 1'b1);
    chk("lw_ov_held", ov1, 4'b0010);
    tick();
    chk("lw_fired", ov1, 4'b0000);
    // Same-cycle CDB bypass at accept
    instr(R_TYPE, 3'd0, 7'd0); rs1_vt = 7'h47; cdb_valid = 1; cdb_tag = 6'd7; cdb_data = 32'h77;
    tick(); clr(); #1;
    chk("byp_rs1_valid", pk1.rs1_valid, 1'b1);
    chk("byp_rs1_data", pk1.rs1_data, 32'h77);
    tick();
    // Both operands woken by one broadcast while held
    instr(B_TYPE, 3'd0, 7'd0); rs1_vt = 7'h49; rs2_vt = 7'h49; q_ready = 4'b1110;
    tick(); in_valid = 0; cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'h55; #1;
    chk("b_ov", ov1, 4'b0001);
    chk("b_rs2_pending", pk1.rs2_valid, 1'b0);
    tick(); clr(); #1;
    chk("b_rs1_data", pk1.rs1_data, 32'h55);
    chk("b_rs2_data", pk1.rs2_data, 32'h55);
    chk("b_rs2_valid", pk1.rs2_valid, 1'b1);
    tick();
    chk("b_stall", sc1, 16'd4);
    // Held SW squashed by flush; the concurrent instruction is dropped
    instr(S_TYPE, 3'd2, 7'd0); q_ready = 4'b0000;
    tick(); #1;
    chk("sw_ov", ov1, 4'b0010);
    chk("sw_store", pk1.is_store, 1'b1);
    instr(R_TYPE, 3'd0, 7'd0); flush = 1; q_ready = 4'hF; #1;
    chk("flush_in_ready", ir1, 1'b0);
    tick(); clr(); #1;
    chk("flush_ov", ov1, 4'b0000);
    chk("flush_in_ready_after", ir1, 1'b1);
    chk("flush_stall", sc1, 16'd4);
    // JAL accepted but never buffered; x0 source always valid
    instr(J_TYPE, 3'd0, 7'd0);
    #1;
    chk("jal_in_ready", ir1, 1'b1);
    tick(); clr(); #1;
    chk("jal_ov", ov1, 4'b0000);
    instr(R_TYPE, 3'd0, 7'd0); rs1_dec = 5'd0; rs1_vt = 7'h45;
    tick(); clr(); #1;
    chk("x0_rs1_valid", pk1.rs1_valid, 1'b1);
    tick();
    // Long stall: saturation of narrow counter, then reset mid-hold
    instr(LW, 3'd2, 7'd0); q_ready = 4'b0000;
    tick(); in_valid = 0;
    repeat (10) tick();
    chk("sat_stall_wide", sc1, 16'd14);
    chk("sat_stall_lite", sc0, 3'd7);
    chk("sat_ov", ov1, 4'b0010);
    rst = 1;
    tick();
    chk("rst_hold_ov", ov1, 4'b0000);
    chk("rst_hold_stall", sc1, 16'd0);
    rst = 0; q_ready = 4'hF;
    tick();
    chk("rst_hold_in_ready", ir1, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
